// File: rtl/pipe_alu_pkg.sv
// rtl/pipe_alu_pkg.sv - shared func codes and widths for the pipe_alu_core slice
package pipe_alu_pkg;

    localparam int FUNC_W = 4;

    localparam logic [FUNC_W-1:0] FN_ADD = 4'd0;
    localparam logic [FUNC_W-1:0] FN_SUB = 4'd1;
    localparam logic [FUNC_W-1:0] FN_AND = 4'd2;
    localparam logic [FUNC_W-1:0] FN_OR  = 4'd3;
    localparam logic [FUNC_W-1:0] FN_XOR = 4'd4;
    localparam logic [FUNC_W-1:0] FN_SLL = 4'd5;
    localparam logic [FUNC_W-1:0] FN_SRL = 4'd6;
    localparam logic [FUNC_W-1:0] FN_LI  = 4'd7;

endpackage

// File: rtl/pipe_alu_exec.sv
// rtl/pipe_alu_exec.sv - combinational ALU for the EX stage
//   func_i   : operation code (codes 8..15 yield zero)
//   a_i, b_i : operands; shifts use the low $clog2(XLEN) bits of b_i
//   imm_i    : immediate, only used by LI
//   result_o : XLEN-bit result, wraps modulo 2^XLEN
module pipe_alu_exec
    import pipe_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [FUNC_W-1:0] func_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic [XLEN-1:0]   imm_i,
    output logic [XLEN-1:0]   result_o
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b_i[SHW-1:0];

    always_comb begin
        result_o = '0;
        case (func_i)
            FN_ADD:  result_o = a_i + b_i;
            FN_SUB:  result_o = a_i - b_i;
            FN_AND:  result_o = a_i & b_i;
            FN_OR:   result_o = a_i | b_i;
            FN_XOR:  result_o = a_i ^ b_i;
            FN_SLL:  result_o = a_i << shamt;
            FN_SRL:  result_o = a_i >> shamt;
            FN_LI:   result_o = imm_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/pipe_alu_core.sv
// rtl/pipe_alu_core.sv - 3-stage in-order ALU pipeline (ID, EX, WB/out) with full forwarding
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : op handshake; in_ready = !out_valid || out_ready
//   rs1, rs2, rd, func, imm : op fields
//   out_valid / out_ready   : result handshake; backpressure stalls the whole pipe
//   out_data, out_rd    : result value and its destination register
//   retired             : count of handed-off results, wraps
module pipe_alu_core
    import pipe_alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int RIDX_W = $clog2(NREG),
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RIDX_W-1:0] rs1,
    input  logic [RIDX_W-1:0] rs2,
    input  logic [RIDX_W-1:0] rd,
    input  logic [FUNC_W-1:0] func,
    input  logic [XLEN-1:0]   imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [RIDX_W-1:0] out_rd,
    output logic [CNT_W-1:0]  retired
);

    typedef struct packed {
        logic              valid;
        logic [RIDX_W-1:0] rd;
        logic [FUNC_W-1:0] func;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [XLEN-1:0]   imm;
    } stage_t;

    logic [XLEN-1:0]   rf_q [NREG];

    stage_t            ex_q, ex_d;
    logic              wb_valid_q;
    logic [RIDX_W-1:0] wb_rd_q;
    logic [XLEN-1:0]   wb_data_q;

    logic              out_valid_q;
    logic [RIDX_W-1:0] out_rd_q;
    logic [XLEN-1:0]   out_data_q;
    logic [CNT_W-1:0]  retired_q;

    logic              advance;
    logic              accept;
    logic [XLEN-1:0]   ex_result;
    logic [XLEN-1:0]   opa, opb;

    assign advance  = !out_valid_q || out_ready;
    assign accept   = in_valid && advance;
    assign in_ready = advance;

    pipe_alu_exec #(.XLEN(XLEN)) u_exec (
        .func_i   (ex_q.func),
        .a_i      (ex_q.a),
        .b_i      (ex_q.b),
        .imm_i    (ex_q.imm),
        .result_o (ex_result)
    );

    // Operand resolution: youngest producer wins (EX over WB over register file).
    // Once WB moves to the output registers the register file already holds the
    // value, so no third forwarding source is needed.
    always_comb begin
        opa = rf_q[rs1];
        if (wb_valid_q && wb_rd_q == rs1) opa = wb_data_q;
        if (ex_q.valid && ex_q.rd == rs1) opa = ex_result;
        if (rs1 == '0) opa = '0;

        opb = rf_q[rs2];
        if (wb_valid_q && wb_rd_q == rs2) opb = wb_data_q;
        if (ex_q.valid && ex_q.rd == rs2) opb = ex_result;
        if (rs2 == '0) opb = '0;
    end

    // Bubbles carry an all-zero payload so idle beats never show stale data.
    always_comb begin
        ex_d = '0;
        if (accept) begin
            ex_d.valid = 1'b1;
            ex_d.rd    = rd;
            ex_d.func  = func;
            ex_d.a     = opa;
            ex_d.b     = opb;
            ex_d.imm   = imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (advance) begin
            ex_q        <= ex_d;
            wb_valid_q  <= ex_q.valid;
            wb_rd_q     <= ex_q.valid ? ex_q.rd : '0;
            wb_data_q   <= ex_q.valid ? ex_result : '0;
            out_valid_q <= wb_valid_q;
            out_rd_q    <= wb_rd_q;
            out_data_q  <= wb_data_q;
            if (wb_valid_q && wb_rd_q != '0) begin
                rf_q[wb_rd_q] <= wb_data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else if (out_valid_q && out_ready) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign out_valid = out_valid_q;
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_pipe_alu_core.sv
// tb/tb_pipe_alu_core.sv - directed self-checking bench for pipe_alu_core
module tb_pipe_alu_core;
    import pipe_alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  func;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic [31:0] retired;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] r0;

    pipe_alu_core dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .func      (func),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] fn, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im);
        in_valid = 1'b1;
        func = fn; rd = d; rs1 = s1; rs2 = s2; imm = im;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] d, input logic [4:0] r);
        check({tag, " valid"}, out_valid, 1);
        check({tag, " data"}, out_data, d);
        check({tag, " rd"}, out_rd, r);
    endtask

    task automatic expect_none(input string tag);
        check({tag, " novalid"}, out_valid, 0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        rs1 = '0; rs2 = '0; rd = '0; func = '0; imm = '0;
        tick(); tick();
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst out_rd", out_rd, 0);
        check("rst retired", retired, 0);
        reset = 1'b0;
        check("rst in_ready", in_ready, 1);

        // 1: LI, LI, dependent ADD via EX and WB forwarding
        send(FN_LI, 5'd1, 5'd0, 5'd0, 32'd5);
        expect_none("t1 e1");
        send(FN_LI, 5'd2, 5'd0, 5'd0, 32'd3);
        expect_none("t1 e2");
        send(FN_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        expect_beat("t1 li1", 32'd5, 5'd1);
        idle();
        expect_beat("t1 li2", 32'd3, 5'd2);
        idle();
        expect_beat("t1 add", 32'd8, 5'd3);
        idle();
        expect_none("t1 end");
        check("t1 retired", retired, 3);

        // 2: SUB wraps, XOR
        send(FN_SUB, 5'd4, 5'd2, 5'd1, 32'd0);
        send(FN_XOR, 5'd5, 5'd1, 5'd2, 32'd0);
        expect_none("t2 gap");
        idle();
        expect_beat("t2 sub", 32'hFFFF_FFFE, 5'd4);
        idle();
        expect_beat("t2 xor", 32'd6, 5'd5);
        idle();

        // 3: write to x0 produces a beat but is neither stored nor forwarded
        send(FN_LI, 5'd0, 5'd0, 5'd0, 32'd9);
        send(FN_ADD, 5'd6, 5'd0, 5'd1, 32'd0);
        idle();
        expect_beat("t3 li0", 32'd9, 5'd0);
        idle();
        expect_beat("t3 add", 32'd5, 5'd6);

        // 3b: same rd in EX and WB, EX must win
        send(FN_LI, 5'd20, 5'd0, 5'd0, 32'd1);
        send(FN_LI, 5'd20, 5'd0, 5'd0, 32'd2);
        send(FN_ADD, 5'd21, 5'd20, 5'd0, 32'd0);
        expect_beat("t3b a", 32'd1, 5'd20);
        idle();
        expect_beat("t3b b", 32'd2, 5'd20);
        idle();
        expect_beat("t3b fwd", 32'd2, 5'd21);
        idle();
        expect_none("t3b end");

        // 4: backpressure holds everything
        r0 = retired;
        send(FN_LI, 5'd11, 5'd0, 5'd0, 32'd100);
        send(FN_LI, 5'd12, 5'd0, 5'd0, 32'd200);
        send(FN_ADD, 5'd13, 5'd11, 5'd12, 32'd0);
        out_ready = 1'b0;
        in_valid = 1'b1; func = FN_LI; rd = 5'd14; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd77;
        #1;
        check("t4 in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4 stall in_ready", in_ready, 0);
            expect_beat("t4 hold", 32'd100, 5'd11);
        end
        check("t4 retired hold", retired, r0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        expect_beat("t4 r2", 32'd200, 5'd12);
        tick();
        expect_beat("t4 r3", 32'd300, 5'd13);
        tick();
        expect_none("t4 end");
        check("t4 retired", retired, r0 + 32'd3);

        // 5: shifts with a masked shift amount, unused func code
        send(FN_LI, 5'd7, 5'd0, 5'd0, 32'd33);
        send(FN_SLL, 5'd8, 5'd1, 5'd2, 32'd0);
        send(FN_SRL, 5'd9, 5'd8, 5'd7, 32'd0);
        expect_beat("t5 li", 32'd33, 5'd7);
        send(4'hF, 5'd15, 5'd1, 5'd2, 32'd0);
        expect_beat("t5 sll", 32'd40, 5'd8);
        idle();
        expect_beat("t5 srl", 32'd20, 5'd9);
        idle();
        expect_beat("t5 f", 32'd0, 5'd15);
        idle();
        expect_none("t5 end");

        // 6: reset flushes in-flight ops and clears the register file
        send(FN_LI, 5'd1, 5'd0, 5'd0, 32'd1);
        send(FN_LI, 5'd2, 5'd0, 5'd0, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6 out_valid", out_valid, 0);
        check("t6 retired", retired, 0);
        check("t6 out_data", out_data, 0);
        send(FN_ADD, 5'd10, 5'd1, 5'd2, 32'd0);
        expect_none("t6 e1");
        idle();
        expect_none("t6 e2");
        idle();
        expect_beat("t6 add", 32'd0, 5'd10);
        idle();
        expect_none("t6 end");
        check("t6 retired1", retired, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
